sqrt_iter_engine: RTL
=====================

# sqrt_iter_engine

Parametrised iterative integer square-root engine, the successor to the fixed 32-bit single-bit-per-cycle sqrt core. It computes floor or round-to-nearest sqrt of an unsigned WIDTH-bit operand and also returns the remainder. It retires RADIX_BITS result bits per clock and uses valid/ready handshakes on both sides with output backpressure. It sits behind the memory-mapped accelerator wrapper in the pipelined SoC.

## Interface
- WIDTH, 32: operand width. Must be even and at least 4.
- RADIX_BITS, 1: root bits resolved per COMPUTE cycle. Allowed values are 1 or 2, and RADIX_BITS must divide WIDTH/2.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand offered.
- in_ready  out  1  engine can accept an operand this cycle.
- in_radicand  in  WIDTH  unsigned operand.
- in_round  in  1  0 = floor; 1 = round-to-nearest. Sampled with the operand.
- abort  in  1  synchronous cancel of the operation in flight.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_root  out  WIDTH/2  root.
- out_rem  out  WIDTH/2+1  remainder, radicand − floor_root².
- out_sat  out  1  rounding saturated out_root.
- busy  out  1  state == COMPUTE.

## Operation
- N = WIDTH/(2·RADIX_BITS) compute cycles.
- **States:** IDLE, COMPUTE, DONE.
- **Transitions:**
  - IDLE → COMPUTE on in_valid && in_ready.
  - COMPUTE → DONE when iter == N−1.
  - DONE → IDLE on out_ready when in_valid is low.
  - DONE → COMPUTE on out_ready && in_valid (back-to-back accept).
  - COMPUTE → IDLE on abort. No result is produced.
- **in_ready** = (state==IDLE) || (state==DONE && out_ready). Combinational from out_ready, with no path from in_valid.
- **On accept:** load x=in_radicand, q=0, ac=0, iter=0, and latch round_q=in_round.
- **Radix-2 step**, applied RADIX_BITS times in cascade per cycle:
  - ac' = {ac, x[MSB:MSB−1]}
  - t = ac' − {q, 2'b01}
  - If t ≥ 0: ac=t, q={q,1}. Otherwise ac=ac', q={q,0}.
  - x <<= 2.
- **Accumulator width:** WIDTH/2+2 bits, so the sign bit never truncates.
- **Final result:** floor root = q; out_rem = ac (≤ 2·root).
- **Rounding:** when round_q=1 and rem > root, the root is incremented. If the root is already all-ones, it stays all-ones and out_sat=1. out_rem always reports the floor remainder.
- **Result hold:** out_root, out_rem and out_sat are registered at the COMPUTE→DONE edge and held stable while out_valid && !out_ready.
- **abort:**
  - Ignored in IDLE and DONE. A result already in DONE is not discarded.
  - abort and in_valid in the same IDLE cycle: the accept proceeds.
- **Reset mid-operation:** immediate return to IDLE. The in-flight result is lost.

## Timing
- **Reset values:**
  - in_ready=1, out_valid=0, busy=0, out_sat=0.
  - out_root=0, out_rem=0.
  - Internal x, q, ac and iter = 0.
- **Latency:** operand accepted at edge E0 → out_valid high after edge E0+N. Examples: 16 cycles for WIDTH=32/RADIX_BITS=1, 8 cycles for RADIX_BITS=2.
- **Throughput:** one result per N+1 cycles with out_ready held high. The back-to-back accept in DONE removes the IDLE bubble.
- **Outputs:** out_valid and busy are registered state decodes.

## Structure
- **Package sqrt_pkg:**
  - state enum (2-bit): IDLE, COMPUTE, DONE.
  - Helper function for the accumulator width, WIDTH/2+2.
- **Sub-module sqrt_step:**
  - Purely combinational, parametrised on WIDTH.
  - One radix-2 step: ac, q and top two x bits in → ac, q out.
  - Instantiated RADIX_BITS times in a generate chain.
- **Top level:** FSM, iteration counter (clog2(N) bits), operand/result registers, rounding logic.

## Test plan
- **Floor mode:** WIDTH=32, RADIX_BITS=1, 144, round=0 → root 12, rem 0, out_valid exactly 16 cycles after accept. Also 0 → root 0, rem 0.
- **Maximum operand:** 32'hFFFF_FFFF, round=0 → root 65535, rem 131070. With round=1 → root 65535, out_sat=1.
- **Rounding boundary:**
  - 156 → root 12 (rem 12, not >12).
  - 157 → root 13 (rem 13).
  - 150 → root 12.
- **Backpressure:** hold out_ready=0 for 5 cycles → outputs stable and in_ready=0. Then present 81 with out_ready=1 → back-to-back accept in the same cycle, next result 9.
- **abort / reset:**
  - abort at compute cycle 7 → no out_valid, IDLE next cycle.
  - rst asserted mid-COMPUTE → all outputs at reset values immediately.
- **RADIX_BITS=2, WIDTH=16:** 65535 → root 255, rem 510, 4-cycle latency. Random operands are checked against a reference model.

Source files
------------

// File: rtl/sqrt_iter_engine_pkg.sv
// sqrt_pkg: shared types and helpers for the iterative square-root engine.
//   state_t   : engine FSM encoding (IDLE, COMPUTE, DONE), 2 bits.
//   acc_width : partial-remainder width for a given operand width.
package sqrt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // The partial remainder never exceeds 2*root + 1 before the shift-in of
  // two operand bits, so WIDTH/2 + 2 bits hold it without losing the MSB.
  function automatic int acc_width(input int width);
    return width / 2 + 2;
  endfunction

endpackage

// File: rtl/sqrt_iter_engine_step.sv
// sqrt_step: one combinational restoring radix-2 square-root step.
//   i_ac  : partial remainder in
//   i_q   : partial root in
//   i_x2  : next two operand bits (MSB first)
//   o_ac  : updated partial remainder
//   o_q   : updated partial root (one new bit shifted in at the LSB)
module sqrt_step
  import sqrt_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [acc_width(WIDTH)-1:0] i_ac,
  input  logic [WIDTH/2-1:0]          i_q,
  input  logic [1:0]                  i_x2,
  output logic [acc_width(WIDTH)-1:0] o_ac,
  output logic [WIDTH/2-1:0]          o_q
);

  localparam int H  = WIDTH / 2;
  localparam int AW = acc_width(WIDTH);

  logic [AW-1:0] w_ac_sh;
  logic [AW:0]   w_diff;
  logic          w_ge;
  logic [1:0]    w_unused_ac_top;

  // The top two remainder bits are always zero on entry (see acc_width).
  assign w_unused_ac_top = i_ac[AW-1:AW-2];
  assign w_ac_sh         = {i_ac[AW-3:0], i_x2};

  // One extra bit on the trial subtraction gives a clean sign.
  assign w_diff = {1'b0, w_ac_sh} - {1'b0, i_q, 2'b01};
  assign w_ge   = ~w_diff[AW];

  assign o_ac = w_ge ? w_diff[AW-1:0] : w_ac_sh;
  assign o_q  = {i_q[H-2:0], w_ge};

endmodule

// File: rtl/sqrt_iter_engine.sv
// sqrt_iter_engine: iterative unsigned integer square root, RADIX_BITS root
// bits per cycle, floor or round-to-nearest, with remainder.
//   clk, rst      : clock, asynchronous active-high reset
//   in_valid/ready: operand handshake (in_radicand, in_round)
//   abort         : cancels an operation in COMPUTE, no result produced
//   out_valid/ready: result handshake (out_root, out_rem, out_sat)
//   busy          : engine is in COMPUTE
//   dbg_state     : current FSM state
// Handshake rule (both sides): a transfer happens on a rising edge where
// valid && ready are both high; the producer holds valid and data stable
// until that edge; in_ready depends on state and out_ready only.
module sqrt_iter_engine
  import sqrt_pkg::*;
#(
  parameter int WIDTH      = 32,  // even, >= 4
  parameter int RADIX_BITS = 1    // 1 or 2, divides WIDTH/2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_radicand,
  input  logic                 in_round,
  input  logic                 abort,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH/2-1:0]   out_root,
  output logic [WIDTH/2:0]     out_rem,
  output logic                 out_sat,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  localparam int H  = WIDTH / 2;
  localparam int AW = acc_width(WIDTH);
  localparam int N  = WIDTH / (2 * RADIX_BITS);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  state_t           r_state;
  logic [WIDTH-1:0] r_x;
  logic [H-1:0]     r_q;
  logic [AW-1:0]    r_ac;
  logic [IW-1:0]    r_iter;
  logic             r_round;
  logic [H-1:0]     r_root;
  logic [H:0]       r_rem;
  logic             r_sat;

  logic [RADIX_BITS:0][AW-1:0] w_ac;
  logic [RADIX_BITS:0][H-1:0]  w_q;
  logic                        w_accept;
  logic                        w_last;
  logic [H-1:0]                w_fq;
  logic [AW-1:0]               w_frem;
  logic                        w_round_up;
  logic                        w_all_ones;
  logic                        w_sat;
  logic [H-1:0]                w_root;
  logic                        w_unused_rem_top;

  // Cascade of radix-2 steps; step g consumes operand bits 2g/2g+1 from the top.
  assign w_ac[0] = r_ac;
  assign w_q[0]  = r_q;
  for (genvar g = 0; g < RADIX_BITS; g++) begin : g_step
    sqrt_step #(.WIDTH(WIDTH)) u_step (
      .i_ac (w_ac[g]),
      .i_q  (w_q[g]),
      .i_x2 (r_x[WIDTH-1-2*g -: 2]),
      .o_ac (w_ac[g+1]),
      .o_q  (w_q[g+1])
    );
  end

  assign in_ready  = (r_state == ST_IDLE) || (r_state == ST_DONE && out_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_iter == IW'(N - 1));

  // Rounding: rem > root means x >= root^2 + root + 1, i.e. x is closer to
  // (root+1)^2; an all-ones root cannot grow and saturates instead.
  assign w_fq             = w_q[RADIX_BITS];
  assign w_frem           = w_ac[RADIX_BITS];
  assign w_unused_rem_top = w_frem[AW-1];
  assign w_round_up       = r_round && (w_frem > AW'(w_fq));
  assign w_all_ones       = &w_fq;
  assign w_sat            = w_round_up && w_all_ones;
  assign w_root           = (w_round_up && !w_all_ones) ? w_fq + H'(1) : w_fq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_x     <= '0;
      r_q     <= '0;
      r_ac    <= '0;
      r_iter  <= '0;
      r_round <= 1'b0;
      r_root  <= '0;
      r_rem   <= '0;
      r_sat   <= 1'b0;
    end else if (w_accept) begin
      // Accept from IDLE or back-to-back from DONE.
      r_state <= ST_COMPUTE;
      r_x     <= in_radicand;
      r_q     <= '0;
      r_ac    <= '0;
      r_iter  <= '0;
      r_round <= in_round;
    end else begin
      case (r_state)
        ST_COMPUTE: begin
          if (abort) begin
            r_state <= ST_IDLE;
          end else begin
            r_x    <= r_x << (2 * RADIX_BITS);
            r_q    <= w_fq;
            r_ac   <= w_frem;
            r_iter <= r_iter + IW'(1);
            if (w_last) begin
              r_state <= ST_DONE;
              r_root  <= w_root;
              r_rem   <= w_frem[H:0];
              r_sat   <= w_sat;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        ST_IDLE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state == ST_COMPUTE);
  assign out_root  = r_root;
  assign out_rem   = r_rem;
  assign out_sat   = r_sat;
  assign dbg_state = r_state;

endmodule
